// File: rtl/cpu_datapath.sv
`timescale 1ns/1ps
// cpu_datapath: register and ALU datapath of the accumulator CPU.
// It owns PC, IRU, IRL, AC and SP, drives the single-port memory interface
// and returns opcode/ZFLG/NFLG to the control sequencer. State updates on the
// rising edge, half-way through each sequencer state.
// Build option: define DP_STACK_GUARD_EN to enable the stack overflow/underflow
// guard (sticky STK_ERR, suppressed SP update, blocked overflow write).
module cpu_datapath #(
  parameter logic [7:0] PC_INIT     = 8'h00,
  parameter logic [7:0] SP_INIT     = 8'h00,
  parameter logic [7:0] STACK_FLOOR = 8'hC0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       FETCH,
  input  logic       INC_PC,
  input  logic       LOAD_PC,
  input  logic       LOAD_IRU,
  input  logic       LOAD_IRL,
  input  logic       LOAD_AC,
  input  logic       STORE_MEM,
  input  logic       LOAD_SP,
  input  logic       SP_INC,
  input  logic       SP_DEC,
  input  logic       DO_PUSH,
  input  logic       DO_POP,
  input  logic       DO_JSR,
  input  logic       DO_RTS,
  output logic [7:0] opcode,
  output logic       ZFLG,
  output logic       NFLG,
  output logic [7:0] MEM_ADDR,
  output logic [7:0] MEM_WDATA,
  output logic       MEM_WE,
  input  logic [7:0] MEM_RDATA,
  output logic       STK_ERR,
  output logic [7:0] PC_DBG,
  output logic [7:0] AC_DBG,
  output logic [7:0] SP_DBG
);

`ifdef DP_STACK_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  logic [7:0] pc_q, pc_d;
  logic [7:0] iru_q, iru_d;
  logic [7:0] irl_q, irl_d;
  logic [7:0] ac_q, ac_d;
  logic [7:0] sp_q, sp_d;
  logic       stk_err_q, stk_err_d;

  logic [7:0] sp_minus1;
  logic [7:0] sp_plus1;
  logic       stk_ovf;
  logic       stk_unf;

  logic [4:0] alu_op;
  logic       alu_mem_operand;
  logic [7:0] alu_b;
  logic [7:0] alu_res;

  // Stack neighbours and fault detection; the fault terms fold to 0 when the
  // guard is not built in, so SP wraps freely and no write is blocked.
  always_comb begin
    sp_minus1 = sp_q - 8'd1;
    sp_plus1  = sp_q + 8'd1;
    stk_ovf   = GUARD_EN && SP_DEC && !LOAD_SP && (sp_q == STACK_FLOOR);
    stk_unf   = GUARD_EN && SP_INC && (sp_q == SP_INIT);
  end

  // Memory address mux (first match wins), write data and write strobe.
  // The strobe is killed while RESET is high so an interrupted store never lands.
  always_comb begin
    if (FETCH)
      MEM_ADDR = pc_q;
    else if (DO_PUSH || DO_JSR)
      MEM_ADDR = sp_minus1;
    else if (DO_POP || DO_RTS)
      MEM_ADDR = sp_q;
    else
      MEM_ADDR = irl_q;
    MEM_WDATA = DO_JSR ? pc_q : ac_q;
    MEM_WE    = STORE_MEM && !RESET && !stk_ovf;
  end

  // ALU: operand select and result for the op held in IRU[4:0].
  always_comb begin
    alu_op = iru_q[4:0];
    case (alu_op)
      5'h01, 5'h05, 5'h07, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D:
        alu_mem_operand = 1'b1;
      default:
        alu_mem_operand = 1'b0;
    endcase
    alu_b   = alu_mem_operand ? MEM_RDATA : irl_q;
    alu_res = ac_q;
    case (alu_op)
      5'h01, 5'h02: alu_res = alu_b;
      5'h04:        alu_res = '0;
      5'h05, 5'h06: alu_res = ac_q + alu_b;
      5'h07, 5'h08: alu_res = ac_q - alu_b;
      5'h09, 5'h0E: alu_res = ac_q & alu_b;
      5'h0A, 5'h0F: alu_res = ac_q | alu_b;
      5'h0B:        alu_res = ac_q ^ alu_b;
      5'h0C:        alu_res = {alu_b[6:0], 1'b0};
      5'h0D:        alu_res = {1'b0, alu_b[7:1]};
      default:      alu_res = ac_q;
    endcase
  end

  // Next-state for every architectural register from the sequencer strobes.
  always_comb begin
    pc_d      = pc_q;
    iru_d     = iru_q;
    irl_d     = irl_q;
    ac_d      = ac_q;
    sp_d      = sp_q;
    stk_err_d = stk_err_q || stk_ovf || stk_unf;

    if (LOAD_PC)
      pc_d = DO_RTS ? MEM_RDATA : irl_q;
    else if (INC_PC)
      pc_d = pc_q + 8'd1;

    if (LOAD_IRU)
      iru_d = MEM_RDATA;
    if (LOAD_IRL)
      irl_d = MEM_RDATA;

    if (LOAD_AC)
      ac_d = DO_POP ? MEM_RDATA : alu_res;

    // A detected fault freezes SP ahead of every other SP source.
    if (stk_ovf || stk_unf)
      sp_d = sp_q;
    else if (LOAD_SP)
      sp_d = irl_q;
    else if (SP_INC && !SP_DEC)
      sp_d = sp_plus1;
    else if (SP_DEC && !SP_INC)
      sp_d = sp_minus1;
  end

  // Register bank with asynchronous active-high reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q      <= PC_INIT;
      iru_q     <= '0;
      irl_q     <= '0;
      ac_q      <= '0;
      sp_q      <= SP_INIT;
      stk_err_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      iru_q     <= iru_d;
      irl_q     <= irl_d;
      ac_q      <= ac_d;
      sp_q      <= sp_d;
      stk_err_q <= stk_err_d;
    end
  end

  assign opcode  = iru_q;
  assign ZFLG    = (ac_q == 8'h00);
  assign NFLG    = ac_q[7];
  assign STK_ERR = stk_err_q;
  assign PC_DBG  = pc_q;
  assign AC_DBG  = ac_q;
  assign SP_DBG  = sp_q;

endmodule

// File: tb/tb_cpu_datapath.sv
`timescale 1ns/1ps
// tb_cpu_datapath: acts as the control sequencer and the memory for
// cpu_datapath, issuing directed and random two-byte instructions. An
// instruction-level reference model predicts the architectural state after
// each instruction; a monitor compares it when the instruction retires.
module tb_cpu_datapath;

  localparam logic [7:0] PC_INIT = 8'h00;
  localparam logic [7:0] SP_INIT = 8'h00;
  localparam logic [7:0] FLOOR   = 8'hC0;
`ifdef DP_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic fetch, inc_pc, load_pc, load_iru, load_irl, load_ac, store_mem;
    logic load_sp, sp_inc, sp_dec, do_push, do_pop, do_jsr, do_rts;
  } strb_t;

  typedef struct {
    logic [7:0] pc, ac, sp, opc;
    logic       zf, nf, err;
    bit         chk_mem;
    logic [7:0] maddr, mdata;
    bit         is_rst;
    bit         chk_addr;
  } exp_t;

  logic       CLK;
  logic       RESET;
  strb_t      s;
  logic [7:0] opcode, MEM_ADDR, MEM_WDATA, MEM_RDATA, PC_DBG, AC_DBG, SP_DBG;
  logic       ZFLG, NFLG, MEM_WE, STK_ERR;

  logic [7:0] mem [256];
  logic       ld_en;
  logic [7:0] ld_a, ld_d0, ld_d1;
  logic       instr_end;

  logic [7:0] r_pc, r_ac, r_sp;
  logic       r_err;
  logic [7:0] r_opc;
  logic [7:0] r_mem [256];

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  cpu_datapath #(.PC_INIT(PC_INIT), .SP_INIT(SP_INIT), .STACK_FLOOR(FLOOR)) dut (
    .CLK(CLK), .RESET(RESET),
    .FETCH(s.fetch), .INC_PC(s.inc_pc), .LOAD_PC(s.load_pc), .LOAD_IRU(s.load_iru),
    .LOAD_IRL(s.load_irl), .LOAD_AC(s.load_ac), .STORE_MEM(s.store_mem),
    .LOAD_SP(s.load_sp), .SP_INC(s.sp_inc), .SP_DEC(s.sp_dec),
    .DO_PUSH(s.do_push), .DO_POP(s.do_pop), .DO_JSR(s.do_jsr), .DO_RTS(s.do_rts),
    .opcode(opcode), .ZFLG(ZFLG), .NFLG(NFLG),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE), .MEM_RDATA(MEM_RDATA),
    .STK_ERR(STK_ERR), .PC_DBG(PC_DBG), .AC_DBG(AC_DBG), .SP_DBG(SP_DBG)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory: combinational read; DUT writes and program loading on posedge.
  assign MEM_RDATA = mem[MEM_ADDR];
  always @(posedge CLK) begin
    if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
    if (ld_en) begin
      mem[ld_a]         <= ld_d0;
      mem[ld_a + 8'd1]  <= ld_d1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: pops the expectation of each retiring instruction.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (instr_end) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: retire with no expectation queued at %0t", $time);
        end else begin
          e = q.pop_front();
          chk($sformatf("pc(op %02h)", e.opc), PC_DBG, e.pc);
          chk($sformatf("ac(op %02h)", e.opc), AC_DBG, e.ac);
          chk($sformatf("sp(op %02h)", e.opc), SP_DBG, e.sp);
          chk($sformatf("opcode(op %02h)", e.opc), opcode, e.opc);
          chk($sformatf("zflg(op %02h)", e.opc), {7'd0, ZFLG}, {7'd0, e.zf});
          chk($sformatf("nflg(op %02h)", e.opc), {7'd0, NFLG}, {7'd0, e.nf});
          chk($sformatf("stk_err(op %02h)", e.opc), {7'd0, STK_ERR}, {7'd0, e.err});
          if (e.chk_mem)
            chk($sformatf("mem[%02h](op %02h)", e.maddr, e.opc), mem[e.maddr], e.mdata);
          if (e.is_rst)
            chk("mem_we_in_reset", {7'd0, MEM_WE}, 8'd0);
          if (e.chk_addr)
            chk("mem_addr_after_reset", MEM_ADDR, PC_INIT);
        end
      end
    end
  end

  function automatic bit mem_operand(input logic [4:0] op);
    return op inside {5'h01, 5'h05, 5'h07, [5'h09:5'h0D]};
  endfunction

  task automatic fill_state(inout exp_t e);
    e.pc  = r_pc;
    e.ac  = r_ac;
    e.sp  = r_sp;
    e.opc = r_opc;
    e.zf  = (r_ac == 8'h00);
    e.nf  = (r_ac >= 8'h80);
    e.err = r_err;
  endtask

  // Reference model: architectural effect of one whole instruction.
  task automatic model_instr(input logic [7:0] opb, input logic [7:0] arg, output exp_t e);
    logic [4:0] op;
    int         a, b;
    op = opb[4:0];
    e.chk_mem = 0; e.maddr = '0; e.mdata = '0; e.is_rst = 0; e.chk_addr = 0;
    r_opc = opb;
    r_pc  = r_pc + 8'd2;
    case (op)
      5'h10: begin
        r_mem[arg] = r_ac;
        e.chk_mem = 1; e.maddr = arg; e.mdata = r_ac;
      end
      5'h11: if (r_ac >= 8'h80) r_pc = arg;
      5'h12: r_pc = arg;
      5'h13: if (r_ac == 8'h00) r_pc = arg;
      5'h14: r_sp = arg;
      5'h15, 5'h17: begin
        e.chk_mem = 1;
        e.maddr   = r_sp - 8'd1;
        if (GUARD && r_sp == FLOOR) begin
          r_err = 1'b1;
        end else begin
          r_sp = r_sp - 8'd1;
          r_mem[r_sp] = (op == 5'h17) ? r_pc : r_ac;
        end
        e.mdata = r_mem[e.maddr];
        if (op == 5'h17) r_pc = arg;
      end
      5'h16, 5'h18: begin
        if (op == 5'h16) r_ac = r_mem[r_sp];
        else             r_pc = r_mem[r_sp];
        if (GUARD && r_sp == SP_INIT) r_err = 1'b1;
        else                          r_sp = r_sp + 8'd1;
      end
      default: begin
        a = int'(r_ac);
        b = mem_operand(op) ? int'(r_mem[arg]) : int'(arg);
        case (op)
          5'd1, 5'd2:   a = b;
          5'd4:         a = 0;
          5'd5, 5'd6:   a = (a + b) % 256;
          5'd7, 5'd8:   a = (a - b + 256) % 256;
          5'd9, 5'd14:  a = a & b;
          5'd10, 5'd15: a = a | b;
          5'd11:        a = a ^ b;
          5'd12:        a = (b * 2) % 256;
          5'd13:        a = b / 2;
          default:      a = a;
        endcase
        r_ac = 8'(a);
      end
    endcase
    fill_state(e);
  endtask

  task automatic cyc(input strb_t v, input bit last);
    @(negedge CLK);
    s = v; instr_end = last; ld_en = 1'b0;
  endtask

  task automatic place(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] a1;
    a1 = a + 8'd1;
    @(negedge CLK);
    s = '0; instr_end = 1'b0;
    ld_en = 1'b1; ld_a = a; ld_d0 = d0; ld_d1 = d1;
    r_mem[a]  = d0;
    r_mem[a1] = d1;
  endtask

  task automatic fetch_cycles();
    strb_t st;
    st = '0; st.fetch = 1; st.load_iru = 1; st.inc_pc = 1;
    cyc(st, 1'b0);
    st.load_iru = 0; st.load_irl = 1;
    cyc(st, 1'b0);
  endtask

  // Sequencer: loads the instruction at the model PC and plays its states.
  task automatic run(input logic [7:0] opb, input logic [7:0] arg);
    exp_t       e;
    strb_t      st;
    logic [4:0] op;
    place(r_pc, opb, arg);
    model_instr(opb, arg, e);
    q.push_back(e);
    fetch_cycles();
    op = opb[4:0];
    st = '0;
    case (op)
      5'h10: begin st.store_mem = 1; cyc(st, 1'b1); end
      5'h11, 5'h12, 5'h13: begin
        @(negedge CLK);
        st.load_pc = (op == 5'h12) || (op == 5'h11 && NFLG) || (op == 5'h13 && ZFLG);
        s = st; instr_end = 1'b1; ld_en = 1'b0;
      end
      5'h14: begin st.load_sp = 1; cyc(st, 1'b1); end
      5'h15: begin st.store_mem = 1; st.do_push = 1; st.sp_dec = 1; cyc(st, 1'b1); end
      5'h16: begin st.do_pop = 1; st.load_ac = 1; st.sp_inc = 1; cyc(st, 1'b1); end
      5'h17: begin
        st.do_jsr = 1; st.store_mem = 1; st.sp_dec = 1; st.load_pc = 1;
        cyc(st, 1'b1);
      end
      5'h18: begin st.do_rts = 1; st.load_pc = 1; st.sp_inc = 1; cyc(st, 1'b1); end
      default: begin
        if (mem_operand(op)) cyc(st, 1'b0);
        st.load_ac = 1;
        cyc(st, 1'b1);
      end
    endcase
  endtask

  task automatic do_reset(input strb_t v, input bit cm, input logic [7:0] ma);
    exp_t e;
    r_pc = PC_INIT; r_ac = 8'h00; r_sp = SP_INIT; r_err = 1'b0; r_opc = 8'h00;
    e.chk_mem = cm; e.maddr = ma; e.mdata = r_mem[ma];
    e.is_rst = 1; e.chk_addr = v.fetch;
    fill_state(e);
    q.push_back(e);
    @(negedge CLK);
    s = v; RESET = 1'b1; instr_end = 1'b1; ld_en = 1'b0;
    @(negedge CLK);
    RESET = 1'b0; s = '0; instr_end = 1'b0;
  endtask

  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  logic [4:0] op_tab [25];

  initial begin
    strb_t st;
    int    bad;
    op_tab = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08,
               5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F, 5'h10, 5'h11,
               5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h18};
    RESET = 1'b1; s = '0; ld_en = 1'b0; instr_end = 1'b0;
    ld_a = '0; ld_d0 = '0; ld_d1 = '0;
    r_pc = PC_INIT; r_ac = '0; r_sp = SP_INIT; r_err = 1'b0; r_opc = '0;

    for (int i = 0; i < 128; i++)
      place(8'(i * 2), 8'($urandom), 8'($urandom));

    // Reset state with the sequencer sitting in a fetch state.
    st = '0; st.fetch = 1;
    do_reset(st, 1'b0, 8'h00);

    run(8'h02, 8'h05);
    run(8'h06, 8'hFD);
    settle();
    chk("plan_addi_ac", AC_DBG, 8'h02);
    chk("plan_addi_pc", PC_DBG, 8'h04);
    chk("plan_addi_z", {7'd0, ZFLG}, 8'd0);
    run(8'h08, 8'h03);
    settle();
    chk("plan_subi_ac", AC_DBG, 8'hFF);
    chk("plan_subi_n", {7'd0, NFLG}, 8'd1);
    run(8'h11, 8'h40);
    settle();
    chk("plan_jneg_pc", PC_DBG, 8'h40);

    run(8'h14, 8'hE0);
    run(8'h02, 8'hAA);
    run(8'h15, 8'h00);
    settle();
    chk("plan_push_mem", mem[8'hDF], 8'hAA);
    chk("plan_push_sp", SP_DBG, 8'hDF);
    run(8'h04, 8'h00);
    run(8'h16, 8'h00);
    settle();
    chk("plan_pop_ac", AC_DBG, 8'hAA);
    chk("plan_pop_sp", SP_DBG, 8'hE0);

    run(8'h12, 8'h10);
    run(8'h17, 8'h80);
    settle();
    chk("plan_jsr_mem", mem[8'hDF], 8'h12);
    chk("plan_jsr_pc", PC_DBG, 8'h80);
    run(8'h18, 8'h00);
    settle();
    chk("plan_rts_pc", PC_DBG, 8'h12);
    chk("plan_rts_sp", SP_DBG, 8'hE0);

    run(8'h02, 8'h5C);
    run(8'h10, 8'h30);
    run(8'h04, 8'h00);
    run(8'h01, 8'h30);
    settle();
    chk("plan_load_ac", AC_DBG, 8'h5C);

    // Reset pulsed during the write state of a STORE that would write 77.
    run(8'h02, 8'h77);
    place(r_pc, 8'h10, 8'h30);
    fetch_cycles();
    st = '0; st.store_mem = 1;
    do_reset(st, 1'b1, 8'h30);
    settle();
    chk("plan_rst_store_mem", mem[8'h30], 8'h5C);
    chk("plan_rst_pc", PC_DBG, PC_INIT);

    // Push at the stack floor.
    run(8'h02, 8'h3C);
    run(8'h14, 8'hC0);
    run(8'h15, 8'h00);
    settle();
`ifdef DP_STACK_GUARD_EN
    chk("plan_guard_err", {7'd0, STK_ERR}, 8'd1);
    chk("plan_guard_sp", SP_DBG, 8'hC0);
`else
    chk("plan_floor_mem", mem[8'hBF], 8'h3C);
    chk("plan_floor_sp", SP_DBG, 8'hBF);
`endif
    do_reset('0, 1'b0, 8'h00);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] op;
      op = op_tab[$urandom_range(0, 24)];
      run({3'($urandom), op}, 8'($urandom));
    end

    cyc('0, 1'b0);
    settle();
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[8'(i)] !== r_mem[8'(i)]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL memory_image: %0d bytes differ, required 0", bad);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

Register and ALU datapath of the accumulator CPU, directly downstream of the control sequencer. It consumes the sequencer's strobes and owns PC, IRU, IRL, AC and SP. It drives the single-port memory interface and returns `opcode`, `ZFLG` and `NFLG` to the sequencer. All state changes on the rising clock edge, mid-way through each sequencer state, because the sequencer advances on the falling edge.

## Interface
Parameters
- `PC_INIT`, 8'h00: PC value after reset.
- `SP_INIT`, 8'h00: SP value after reset, the empty-stack position; the first push writes 8'hFF.
- `STACK_FLOOR`, 8'hC0: lowest legal SP value; used only under `DP_STACK_GUARD_EN`.

Ports
- `CLK`, in, 1: clock; registers update on posedge.
- `RESET`, in, 1: reset, asynchronous, active-high.
- `FETCH`, `INC_PC`, `LOAD_PC`, `LOAD_IRU`, `LOAD_IRL`, `LOAD_AC`, `STORE_MEM`, in, 1 each: sequencer strobes.
- `LOAD_SP`, `SP_INC`, `SP_DEC`, `DO_PUSH`, `DO_POP`, `DO_JSR`, `DO_RTS`, in, 1 each: stack strobes.
- `opcode`, out, 8: IRU register.
- `ZFLG`, out, 1: AC == 0.
- `NFLG`, out, 1: AC[7].
- `MEM_ADDR`, out, 8: memory address.
- `MEM_WDATA`, out, 8: write data.
- `MEM_WE`, out, 1: write enable, sampled by memory on posedge.
- `MEM_RDATA`, in, 8: combinational read data for `MEM_ADDR`.
- `STK_ERR`, out, 1: sticky stack fault; constant 0 without the macro.
- `PC_DBG`, `AC_DBG`, `SP_DBG`, out, 8 each: register observation.

## Operation
- Address mux, first match wins: FETCH → PC; DO_PUSH or DO_JSR → SP−1; DO_POP or DO_RTS → SP; otherwise → IRL.
- Write: MEM_WE = STORE_MEM. MEM_WDATA = PC when DO_JSR, else AC.
- PC: LOAD_PC with DO_RTS loads MEM_RDATA. LOAD_PC without DO_RTS loads IRL. Otherwise INC_PC adds 1 modulo 256. LOAD_PC has priority over INC_PC.
- IR: LOAD_IRU loads IRU ← MEM_RDATA. LOAD_IRL loads IRL ← MEM_RDATA.
- SP priority: LOAD_SP (SP ← IRL) first. SP_INC and SP_DEC together hold SP. SP_INC alone adds 1; SP_DEC alone subtracts 1. Arithmetic wraps modulo 256.
- AC on LOAD_AC:
  - DO_POP loads AC ← MEM_RDATA.
  - Otherwise the result comes from op = IRU[4:0]. The operand B is MEM_RDATA for ops 01, 05, 07, 09–0D, and IRL otherwise.
  - 00 hold; 01/02 load B; 04 clear; 05/06 AC+B; 07/08 AC−B (8-bit, carry dropped); 09/0E AND; 0A/0F OR; 0B XOR; 0C B<<1; 0D B>>1 logical. Any other op holds AC.
  - Opcode bits 7:5 are ignored for the ALU.
- Flags and `opcode` are combinational from the registers.

## Timing
- Reset: PC=PC_INIT, IRU=IRL=AC=0, SP=SP_INIT, STK_ERR=0.
  - Consequently opcode=0, ZFLG=1, NFLG=0, MEM_WE=0, MEM_ADDR=PC_INIT.
  - Reset asserted mid-instruction discards the instruction. Any in-flight write is not performed: MEM_WE is forced to 0 while RESET is asserted.
- Latency: a strobe asserted in a sequencer state takes effect at the posedge inside that state. Flags are valid before the next negedge, so conditional jumps see the AC written by the previous instruction.
- PUSH and JSR are single-cycle. The write goes to SP−1 and SP becomes SP−1 on the same edge.
- POP and RTS read at the current SP and increment SP on the same edge.
- A memory-operand instruction needs IRL stable for one state before LOAD_AC. The sequencer provides this idle read state.

## Configuration
- `DP_STACK_GUARD_EN` defined:
  - Overflow is SP_DEC (without LOAD_SP) while SP == STACK_FLOOR.
  - Underflow is SP_INC while SP == SP_INIT.
  - On either fault, STK_ERR is set and held until RESET, and the SP update is suppressed.
  - On overflow, MEM_WE is additionally gated to 0 for that cycle; for JSR, LOAD_PC still takes effect.
- Not defined: SP wraps freely and STK_ERR is tied to 0.

## Test plan
- Reset, then LOADI 8'h05 (02 05) and ADDI 8'hFD (06 FD) → AC=8'h02, ZFLG=0, NFLG=0, PC=4.
- SUBI 8'h03 from AC=8'h02 → AC=8'hFF, NFLG=1. The following JNEG 8'h40 (11 40) → PC=8'h40.
- LOADSP 8'hE0, then PUSH with AC=8'hAA → M[8'hDF]=8'hAA, SP=8'hDF. Then CLR and POP → AC=8'hAA, SP=8'hE0.
- JSR 8'h80 executed from PC=8'h10 (PC already 8'h12) → M[SP−1]=8'h12, PC=8'h80. RTS → PC=8'h12, SP restored.
- STORE 8'h30 with AC=8'h5C, then LOAD 8'h30 after CLR → AC=8'h5C. RESET pulsed during STORE's write state → M[8'h30] unchanged, all registers at reset values.
- With `DP_STACK_GUARD_EN`, SP=8'hC0 and PUSH → no write, SP=8'hC0, STK_ERR=1. Without the macro → write to 8'hBF, SP=8'hBF.
